// File: rtl/fp_align_pipe_if.sv
// Operand/result bus of the alignment pipe: upstream valid/ready with the
// operand pair, and downstream valid/ready with the aligned pair.
interface fp_align_pipe_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 24,
   parameter int GRS_W  = 3
);
   logic                      in_valid_i;
   logic                      in_ready_o;
   logic                      a_sign_i;
   logic [EXP_W-1:0]          a_exp_i;
   logic [MANT_W-1:0]         a_mant_i;
   logic                      b_sign_i;
   logic [EXP_W-1:0]          b_exp_i;
   logic [MANT_W-1:0]         b_mant_i;
   logic                      out_valid_o;
   logic                      out_ready_i;
   logic [EXP_W-1:0]          exp_o;
   logic                      big_sign_o;
   logic                      small_sign_o;
   logic [MANT_W+GRS_W-1:0]   big_mant_o;
   logic [MANT_W+GRS_W-1:0]   small_mant_o;
   logic                      swapped_o;
   logic                      eff_sub_o;

   modport slave (
      input  in_valid_i, a_sign_i, a_exp_i, a_mant_i,
             b_sign_i, b_exp_i, b_mant_i, out_ready_i,
      output in_ready_o, out_valid_o, exp_o, big_sign_o, small_sign_o,
             big_mant_o, small_mant_o, swapped_o, eff_sub_o
   );

   modport master (
      output in_valid_i, a_sign_i, a_exp_i, a_mant_i,
             b_sign_i, b_exp_i, b_mant_i, out_ready_i,
      input  in_ready_o, out_valid_o, exp_o, big_sign_o, small_sign_o,
             big_mant_o, small_mant_o, swapped_o, eff_sub_o
   );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment: order the pair by magnitude, then right-shift
// the smaller mantissa to the larger exponent keeping guard/round/sticky.
module fp_align_pipe #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 24,
   parameter int GRS_W  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   fp_align_pipe_if.slave    bus
);
   localparam int EXT_W = MANT_W + GRS_W;
   localparam int CMP_W = (EXP_W > 32) ? EXP_W : 32;

   // Shift right by diff; every dropped bit (or the whole operand once the
   // shift passes the extended width) collapses into bit 0 as sticky.
   function automatic logic [EXT_W-1:0] align_sticky(
      input logic [MANT_W-1:0] mant,
      input logic [EXP_W-1:0]  diff
   );
      logic [EXT_W-1:0] ext;
      logic [EXT_W-1:0] shifted;
      logic [EXT_W-1:0] lost_mask;
      logic             sticky;
      ext = {mant, {GRS_W{1'b0}}};
      if (CMP_W'(diff) < CMP_W'(EXT_W)) begin
         shifted   = ext >> diff;
         lost_mask = ~({EXT_W{1'b1}} << diff);
         sticky    = |(ext & lost_mask);
      end else begin
         shifted = '0;
         sticky  = |ext;
      end
      return shifted | {{(EXT_W-1){1'b0}}, sticky};
   endfunction

   logic              w_s2_drain;
   logic              w_s2_open;
   logic              w_s1_adv;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_a_wins;
   logic              w_big_sign;
   logic              w_small_sign;
   logic [EXP_W-1:0]  w_big_exp;
   logic [EXP_W-1:0]  w_small_exp;
   logic [MANT_W-1:0] w_big_mant;
   logic [MANT_W-1:0] w_small_mant;

   logic              r_vld_p1;
   logic              r_big_sign_p1;
   logic              r_small_sign_p1;
   logic [EXP_W-1:0]  r_big_exp_p1;
   logic [MANT_W-1:0] r_big_mant_p1;
   logic [MANT_W-1:0] r_small_mant_p1;
   logic [EXP_W-1:0]  r_diff_p1;
   logic              r_swapped_p1;
   logic              r_eff_sub_p1;

   logic              r_vld_p2;
   logic              r_big_sign_p2;
   logic              r_small_sign_p2;
   logic [EXP_W-1:0]  r_exp_p2;
   logic [EXT_W-1:0]  r_big_mant_p2;
   logic [EXT_W-1:0]  r_small_mant_p2;
   logic              r_swapped_p2;
   logic              r_eff_sub_p2;

   assign w_s2_drain = r_vld_p2 & bus.out_ready_i;
   assign w_s2_open  = ~r_vld_p2 | w_s2_drain;
   assign w_s1_adv   = r_vld_p1 & w_s2_open;
   assign w_in_ready = ~r_vld_p1 | w_s1_adv;
   assign w_in_fire  = bus.in_valid_i & w_in_ready;

   // A wins ties so equal magnitudes never report a swap.
   assign w_a_wins     = {bus.a_exp_i, bus.a_mant_i} >= {bus.b_exp_i, bus.b_mant_i};
   assign w_big_sign   = w_a_wins ? bus.a_sign_i : bus.b_sign_i;
   assign w_small_sign = w_a_wins ? bus.b_sign_i : bus.a_sign_i;
   assign w_big_exp    = w_a_wins ? bus.a_exp_i  : bus.b_exp_i;
   assign w_small_exp  = w_a_wins ? bus.b_exp_i  : bus.a_exp_i;
   assign w_big_mant   = w_a_wins ? bus.a_mant_i : bus.b_mant_i;
   assign w_small_mant = w_a_wins ? bus.b_mant_i : bus.a_mant_i;

   // S1: compare/swap
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_vld_p1        <= 1'b0;
         r_big_sign_p1   <= 1'b0;
         r_small_sign_p1 <= 1'b0;
         r_big_exp_p1    <= '0;
         r_big_mant_p1   <= '0;
         r_small_mant_p1 <= '0;
         r_diff_p1       <= '0;
         r_swapped_p1    <= 1'b0;
         r_eff_sub_p1    <= 1'b0;
      end else begin
         if (w_in_ready) begin
            r_vld_p1 <= bus.in_valid_i;
         end
         if (w_in_fire) begin
            r_big_sign_p1   <= w_big_sign;
            r_small_sign_p1 <= w_small_sign;
            r_big_exp_p1    <= w_big_exp;
            r_big_mant_p1   <= w_big_mant;
            r_small_mant_p1 <= w_small_mant;
            r_diff_p1       <= w_big_exp - w_small_exp;
            r_swapped_p1    <= ~w_a_wins;
            r_eff_sub_p1    <= bus.a_sign_i ^ bus.b_sign_i;
         end
      end
   end

   // S2: alignment shift
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_vld_p2        <= 1'b0;
         r_big_sign_p2   <= 1'b0;
         r_small_sign_p2 <= 1'b0;
         r_exp_p2        <= '0;
         r_big_mant_p2   <= '0;
         r_small_mant_p2 <= '0;
         r_swapped_p2    <= 1'b0;
         r_eff_sub_p2    <= 1'b0;
      end else begin
         if (w_s2_open) begin
            r_vld_p2 <= r_vld_p1;
         end
         if (w_s1_adv) begin
            r_big_sign_p2   <= r_big_sign_p1;
            r_small_sign_p2 <= r_small_sign_p1;
            r_exp_p2        <= r_big_exp_p1;
            r_big_mant_p2   <= {r_big_mant_p1, {GRS_W{1'b0}}};
            r_small_mant_p2 <= align_sticky(r_small_mant_p1, r_diff_p1);
            r_swapped_p2    <= r_swapped_p1;
            r_eff_sub_p2    <= r_eff_sub_p1;
         end
      end
   end

   assign bus.in_ready_o   = w_in_ready;
   assign bus.out_valid_o  = r_vld_p2;
   assign bus.exp_o        = r_exp_p2;
   assign bus.big_sign_o   = r_big_sign_p2;
   assign bus.small_sign_o = r_small_sign_p2;
   assign bus.big_mant_o   = r_big_mant_p2;
   assign bus.small_mant_o = r_small_mant_p2;
   assign bus.swapped_o    = r_swapped_p2;
   assign bus.eff_sub_o    = r_eff_sub_p2;
endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe: directed literal cases, backpressure, mid-flight
// reset and a randomized stream checked against a queue-based model.
module tb_fp_align_pipe;
   typedef struct packed {
      logic [7:0]  e;
      logic        bs;
      logic        ss;
      logic [26:0] bm;
      logic [26:0] sm;
      logic        sw;
      logic        es;
   } res_t;

   logic clk = 1'b0;
   logic rst_ni;
   always #5 clk = ~clk;

   fp_align_pipe_if #(.EXP_W(8), .MANT_W(24), .GRS_W(3)) bus();
   fp_align_pipe #(.EXP_W(8), .MANT_W(24), .GRS_W(3)) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   int   tests = 0;
   int   fails = 0;
   int   drained = 0;
   res_t expq[$];
   logic hold_pending = 1'b0;
   res_t held;
   logic saw_not_ready = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: order by magnitude, shift as integers, sticky = nonzero remainder.
   function automatic res_t model(input logic as, input logic [7:0] ae, input logic [23:0] am,
                                  input logic bs, input logic [7:0] be, input logic [23:0] bm);
      res_t r;
      longint unsigned amag, bmag, ext, sh;
      logic abig, st;
      int d;
      amag = {ae, am};
      bmag = {be, bm};
      abig = (amag >= bmag);
      r.e  = abig ? ae : be;
      r.bs = abig ? as : bs;
      r.ss = abig ? bs : as;
      r.sw = ~abig;
      r.es = as ^ bs;
      r.bm = 27'((abig ? longint'(am) : longint'(bm)) * 8);
      d    = abig ? (int'(ae) - int'(be)) : (int'(be) - int'(ae));
      ext  = (abig ? longint'(bm) : longint'(am)) * 8;
      if (d >= 27) begin
         sh = 0;
         st = (ext != 0);
      end else begin
         sh = ext / (64'd1 << d);
         st = (ext % (64'd1 << d)) != 0;
      end
      r.sm = 27'(sh) | 27'(st);
      return r;
   endfunction

   always @(negedge clk) begin
      res_t got, e;
      got = {bus.exp_o, bus.big_sign_o, bus.small_sign_o, bus.big_mant_o,
             bus.small_mant_o, bus.swapped_o, bus.eff_sub_o};
      if (!bus.in_ready_o && rst_ni) saw_not_ready = 1'b1;
      if (hold_pending) begin
         chk("stall_valid", bus.out_valid_o, 1);
         chk("stall_hold", got, held);
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
         drained++;
         if (expq.size() == 0) begin
            chk("out_without_input", bus.out_valid_o, 0);
         end else begin
            e = expq.pop_front();
            chk("exp_o", got.e, e.e);
            chk("big_sign_o", got.bs, e.bs);
            chk("small_sign_o", got.ss, e.ss);
            chk("big_mant_o", got.bm, e.bm);
            chk("small_mant_o", got.sm, e.sm);
            chk("swapped_o", got.sw, e.sw);
            chk("eff_sub_o", got.es, e.es);
         end
      end
      hold_pending = rst_ni && (bus.out_valid_o === 1'b1) && !bus.out_ready_i;
      held = got;
      if (!rst_ni) expq.delete();
      else if (bus.in_valid_i && bus.in_ready_o === 1'b1)
         expq.push_back(model(bus.a_sign_i, bus.a_exp_i, bus.a_mant_i,
                              bus.b_sign_i, bus.b_exp_i, bus.b_mant_i));
   end

   task automatic set_ops(input logic as, input logic [7:0] ae, input logic [23:0] am,
                          input logic bs, input logic [7:0] be, input logic [23:0] bm);
      bus.a_sign_i = as; bus.a_exp_i = ae; bus.a_mant_i = am;
      bus.b_sign_i = bs; bus.b_exp_i = be; bus.b_mant_i = bm;
   endtask

   // Literal expectation two edges after acceptance into an empty pipe.
   task automatic directed(input string nm,
                           input logic as, input logic [7:0] ae, input logic [23:0] am,
                           input logic bs, input logic [7:0] be, input logic [23:0] bm,
                           input logic [7:0] xe, input logic [26:0] xbm, input logic [26:0] xsm,
                           input logic xsw, input logic xes, input logic xbs, input logic xss);
      set_ops(as, ae, am, bs, be, bm);
      bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_valid"}, bus.out_valid_o, 1);
      chk({nm, "_exp"}, bus.exp_o, xe);
      chk({nm, "_bigm"}, bus.big_mant_o, xbm);
      chk({nm, "_smallm"}, bus.small_mant_o, xsm);
      chk({nm, "_swap"}, bus.swapped_o, xsw);
      chk({nm, "_effsub"}, bus.eff_sub_o, xes);
      chk({nm, "_bsign"}, bus.big_sign_o, xbs);
      chk({nm, "_ssign"}, bus.small_sign_o, xss);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic as, input logic [7:0] ae, input logic [23:0] am,
                       input logic bs, input logic [7:0] be, input logic [23:0] bm);
      logic r;
      r = 1'b0;
      set_ops(as, ae, am, bs, be, bm);
      bus.in_valid_i = 1'b1;
      for (int k = 0; k < 50 && !r; k++) begin
         @(negedge clk);
         r = bus.in_ready_o;
         @(posedge clk); #1;
      end
      chk("send_accepted", r, 1);
   endtask

   task automatic send_rand();
      send(1'($urandom), 8'($urandom), 24'($urandom) | 24'h800000,
           1'($urandom), 8'($urandom), 24'($urandom) | 24'h800000);
   endtask

   initial begin
      logic [7:0]  ae;
      logic [23:0] am;
      int d0;
      rst_ni = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      set_ops(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_in_ready", bus.in_ready_o, 1);
      chk("rst_exp", bus.exp_o, 0);
      chk("rst_bigm", bus.big_mant_o, 0);
      chk("rst_smallm", bus.small_mant_o, 0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      directed("aligned", 0, 130, 24'hC00000, 0, 128, 24'h800000,
               130, 27'h6000000, 27'h1000000, 0, 0, 0, 0);
      directed("swap", 1, 100, 24'h800001, 0, 103, 24'hFFFFFF,
               103, 27'h7FFFFF8, 27'h0800001, 1, 1, 0, 1);
      directed("diff27", 0, 154, 24'h800000, 1, 127, 24'h800000,
               154, 27'h4000000, 27'h0000001, 0, 1, 0, 1);
      directed("diff200", 0, 210, 24'h800000, 0, 10, 24'h000000,
               210, 27'h4000000, 27'h0000000, 0, 0, 0, 0);
      directed("tie", 0, 127, 24'h900000, 1, 127, 24'hA00000,
               127, 27'h5000000, 27'h4800000, 1, 1, 1, 0);
      directed("ident", 1, 127, 24'h900000, 0, 127, 24'h900000,
               127, 27'h4800000, 27'h4800000, 0, 1, 1, 0);
      directed("diff26", 0, 153, 24'h800001, 0, 127, 24'h800001,
               153, 27'h4000008, 27'h0000001, 0, 0, 0, 0);

      // Backpressure: four pairs back-to-back, first result stalled 3 cycles.
      saw_not_ready = 1'b0;
      d0 = drained;
      fork
         begin
            for (int i = 0; i < 4; i++) send_rand();
            bus.in_valid_i = 1'b0;
         end
         begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
               @(posedge clk); #1;
               seen = bus.out_valid_o;
            end
            chk("bp_first_valid", seen, 1);
            bus.out_ready_i = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready_i = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("bp_in_ready_dropped", saw_not_ready, 1);
      chk("bp_count", drained - d0, 4);
      chk("bp_queue_empty", expq.size(), 0);

      // Reset with both stages occupied.
      bus.out_ready_i = 1'b0;
      send_rand();
      send_rand();
      bus.in_valid_i = 1'b0;
      chk("prerst_valid", bus.out_valid_o, 1);
      rst_ni = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", bus.out_valid_o, 0);
      chk("midrst_in_ready", bus.in_ready_o, 1);
      chk("midrst_exp", bus.exp_o, 0);
      chk("midrst_bigm", bus.big_mant_o, 0);
      chk("midrst_smallm", bus.small_mant_o, 0);
      chk("midrst_swap", bus.swapped_o, 0);
      rst_ni = 1'b1;
      bus.out_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("postrst_quiet", bus.out_valid_o, 0);
      end

      // Randomized stream with random backpressure and near exponents.
      for (int c = 0; c < 600; c++) begin
         ae = 8'($urandom);
         am = 24'($urandom);
         if ($urandom_range(0, 3) != 0) am[23] = 1'b1;
         bus.a_sign_i = 1'($urandom);
         bus.a_exp_i  = ae;
         bus.a_mant_i = am;
         bus.b_sign_i = 1'($urandom);
         case ($urandom_range(0, 3))
            0: bus.b_exp_i = 8'($urandom);
            1: bus.b_exp_i = ae;
            default: bus.b_exp_i = ae + 8'($urandom_range(0, 60)) - 8'd30;
         endcase
         bus.b_mant_i = ($urandom_range(0, 7) == 0) ? am : 24'($urandom);
         bus.in_valid_i  = ($urandom_range(0, 9) < 7);
         bus.out_ready_i = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("final_queue_empty", expq.size(), 0);
      chk("final_out_valid", bus.out_valid_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
